std_skid_buffer: RTL and testbench

Two-entry elastic pipeline stage with a valid/ready handshake on both sides. It is built from the same registered-storage style as the standard DFF cells. It sits between a producer and a downstream register stage, and registers both the data path and the ready path. This breaks the combinational `m_ready` → `s_ready` chain while sustaining one transfer per cycle. It is the standard way to insert a timing cut into a handshaked datapath in the core.

---
 rtl/std_skid_buffer.sv | 108 ++++++++++
 tb/tb_std_skid_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/std_skid_buffer.sv
// std_skid_buffer: two-entry elastic stage with registered valid/data/ready.
// The m_ready -> s_ready combinational chain is cut: s_ready, m_valid and
// m_data all come straight from flops, while a skid register absorbs the one
// beat that arrives the cycle the downstream stalls.
// Optional feature macro: STD_SKID_BUFFER_FLUSH_EN adds a 'flush' input that
// empties the stage without touching the data registers.
module std_skid_buffer #(
    parameter int                    DATA_WIDTH       = 1,
    parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef STD_SKID_BUFFER_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [DATA_WIDTH-1:0] m_data
);

    // Occupancy: EMPTY = 0 entries, BUSY = main only, FULL = main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t                state_q, state_n;
    logic                  m_valid_q, m_valid_n;
    logic                  s_ready_q, s_ready_n;
    logic [DATA_WIDTH-1:0] main_q, main_n;
    logic [DATA_WIDTH-1:0] skid_q, skid_n;
    logic                  in_xfer, out_xfer;

    // Handshakes use only registered readiness/validity, so no input reaches
    // an output without passing through a flop.
    assign in_xfer  = s_valid & s_ready_q;
    assign out_xfer = m_valid_q & m_ready;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;

    // Next-state, next-data and next registered handshake outputs.
    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_n  = s_data;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_n = s_data;
                end else if (in_xfer) begin
                    skid_n  = s_data;
                    state_n = FULL;
                end else if (out_xfer) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                // s_ready is low here, so s_valid cannot cause a transfer.
                if (out_xfer) begin
                    main_n  = skid_q;
                    state_n = BUSY;
                end
            end
            default: state_n = EMPTY;
        endcase
`ifdef STD_SKID_BUFFER_FLUSH_EN
        // Flush empties the stage; any beat accepted this cycle is dropped
        // and both data registers keep their current contents.
        if (flush) begin
            state_n = EMPTY;
            main_n  = main_q;
            skid_n  = skid_q;
        end
`endif
        m_valid_n = (state_n == BUSY) || (state_n == FULL);
        s_ready_n = (state_n != FULL);
    end

    // State, payload and handshake registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            main_q    <= DATA_RESET_VALUE;
            skid_q    <= DATA_RESET_VALUE;
        end else begin
            state_q   <= state_n;
            m_valid_q <= m_valid_n;
            s_ready_q <= s_ready_n;
            main_q    <= main_n;
            skid_q    <= skid_n;
        end
    end

endmodule

// File: tb/tb_std_skid_buffer.sv
// Bench for std_skid_buffer: directed phases plus random throttling, checked
// against an occupancy-queue reference model (size 0..2, FIFO order).
module tb_std_skid_buffer;

    localparam int         W   = 8;
    localparam logic [7:0] RST = 8'h3C;

    logic         clk = 1'b0;
    logic         reset, s_valid, s_ready, m_valid, m_ready, flush;
    logic [W-1:0] s_data, m_data;

    int checks = 0;
    int errors = 0;

    // Reference model: items held by the stage, and the value main shows.
    logic [W-1:0] mq[$];
    logic [W-1:0] last = RST;
    int           m_outs = 0;
    // Values the DUT actually handed downstream.
    logic [W-1:0] dut_out[$];

    always #5 clk = ~clk;

    std_skid_buffer #(.DATA_WIDTH(W), .DATA_RESET_VALUE(RST)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
`ifdef STD_SKID_BUFFER_FLUSH_EN
        .flush   (flush),
`endif
        .m_data  (m_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs must match the model state; inputs were just changed, so this
    // also catches any combinational input-to-output path.
    task automatic chk_model(input string tag);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(mq.size() > 0));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(mq.size() < 2));
        chk({tag, ".m_data"},  32'(m_data),  32'(last));
    endtask

    // One cycle: drive at negedge, check, record DUT output, clock, model.
    task automatic step(input string tag, input bit r, input bit sv,
                        input logic [W-1:0] sd, input bit mr, input bit fl);
        bit in_x, out_x;
        @(negedge clk);
        reset = r; s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        #1;
        chk_model(tag);
        if (!r && m_valid && m_ready) dut_out.push_back(m_data);
        @(posedge clk);
        if (r) begin
            mq.delete();
            last = RST;
        end else begin
            in_x  = sv && (mq.size() < 2);
            out_x = mr && (mq.size() > 0);
            if (out_x) begin
                void'(mq.pop_front());
                m_outs++;
            end
            if (in_x) mq.push_back(sd);
`ifdef STD_SKID_BUFFER_FLUSH_EN
            if (fl) mq.delete();
`endif
            if (mq.size() > 0) last = mq[0];
        end
    endtask

    initial begin
        logic [W-1:0] exp_seq[$];
        bit fl;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush = 1'b0;

        // Reset held with a live offer: nothing captured.
        step("rst0", 1, 1, 8'h5A, 1, 0);
        step("rst1", 1, 1, 8'h5A, 1, 0);
        step("rst_rel", 0, 0, 8'h00, 0, 0);
        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.m_data", 32'(m_data), 32'(RST));
        chk("rst.s_ready", 32'(s_ready), 32'd1);

        // Streaming 0x01..0x10 with m_ready held high.
        dut_out.delete();
        for (int i = 1; i <= 16; i++) step("stream", 0, 1, 8'(i), 1, 0);
        step("stream_tail", 0, 0, 8'h00, 1, 0);
        chk("stream.count", 32'(dut_out.size()), 32'd16);
        for (int i = 0; i < 16 && i < dut_out.size(); i++)
            chk("stream.order", 32'(dut_out[i]), 32'(i + 1));

        // Backpressure: A1, A2 accepted, A3 held off.
        dut_out.delete();
        step("bp_a1", 0, 1, 8'hA1, 0, 0);
        step("bp_a2", 0, 1, 8'hA2, 0, 0);
        #1;
        chk("bp.s_ready_low", 32'(s_ready), 32'd0);
        chk("bp.m_data_a1", 32'(m_data), 32'hA1);
        for (int i = 0; i < 3; i++) step("bp_hold", 0, 1, 8'hA3, 0, 0);
        chk("bp.m_data_stable", 32'(m_data), 32'hA1);
        for (int i = 0; i < 2; i++) step("bp_drain", 0, 1, 8'hA3, 1, 0);
        for (int i = 0; i < 3; i++) step("bp_tail", 0, 0, 8'h00, 1, 0);
        exp_seq = '{8'hA1, 8'hA2, 8'hA3};
        chk("bp.count", 32'(dut_out.size()), 32'd3);
        for (int i = 0; i < 3 && i < dut_out.size(); i++)
            chk("bp.order", 32'(dut_out[i]), 32'(exp_seq[i]));

        // Mid-operation reset while FULL with 0x11/0x22.
        step("mr_11", 0, 1, 8'h11, 0, 0);
        step("mr_22", 0, 1, 8'h22, 0, 0);
        step("mr_rst", 1, 1, 8'h33, 1, 0);
        #1;
        chk("mr.m_valid", 32'(m_valid), 32'd0);
        chk("mr.s_ready", 32'(s_ready), 32'd1);
        dut_out.delete();
        for (int i = 0; i < 3; i++) step("mr_after", 0, 0, 8'h00, 1, 0);
        chk("mr.no_output", 32'(dut_out.size()), 32'd0);

`ifdef STD_SKID_BUFFER_FLUSH_EN
        // Flush in FULL with m_ready: 0x11 delivered, 0x22 dropped.
        step("fl_11", 0, 1, 8'h11, 0, 0);
        step("fl_22", 0, 1, 8'h22, 0, 0);
        dut_out.delete();
        step("fl_go", 0, 1, 8'h33, 1, 1);
        #1;
        chk("fl.m_valid", 32'(m_valid), 32'd0);
        chk("fl.s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) step("fl_after", 0, 0, 8'h00, 1, 0);
        chk("fl.count", 32'(dut_out.size()), 32'd1);
        if (dut_out.size() > 0) chk("fl.delivered", 32'(dut_out[0]), 32'h11);
`endif

        // Random throttling against the model.
        dut_out.delete();
        m_outs = 0;
        for (int i = 0; i < 10000; i++) begin
            fl = 1'b0;
`ifdef STD_SKID_BUFFER_FLUSH_EN
            fl = ($urandom_range(0, 63) == 0);
`endif
            step("rand", 0, bit'($urandom_range(0, 1)), 8'($urandom),
                 bit'($urandom_range(0, 1)), fl);
        end
        for (int i = 0; i < 4; i++) step("rand_drain", 0, 0, 8'h00, 1, 0);
        chk("rand.out_count", 32'(dut_out.size()), 32'(m_outs));
        chk("rand.empty", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
